// File: rtl/sound_latch_bridge.sv
// Main-CPU to Z80 sound command mailbox: 16-bit command FIFO in,
// 8-bit reply latch out, exposed to the Z80 as I/O ports.
module sound_latch_bridge #(
    parameter int         DEPTH       = 4,
    parameter logic [7:0] STATUS_PORT = 8'h00,
    parameter logic [7:0] CMD_LO_PORT = 8'h10,
    parameter logic [7:0] CMD_HI_PORT = 8'h20,
    parameter logic [7:0] REPLY_PORT  = 8'h30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_main_wr,
    input  logic [15:0] io_main_data,
    output logic        io_main_ready,
    input  logic        io_main_rd,
    output logic [7:0]  io_main_reply,
    output logic        io_main_reply_valid,
    input  logic [15:0] io_cpu_addr,
    input  logic [7:0]  io_cpu_dout,
    output logic [7:0]  io_cpu_din,
    input  logic        io_cpu_rd,
    input  logic        io_cpu_wr,
    input  logic        io_cpu_iorq,
    output logic        io_cpu_int
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_rd_acc_q;
    logic          r_wr_acc_q;
    logic          r_ovf;
    logic          r_reply_valid;
    logic [7:0]    r_reply;
    logic [7:0]    r_din;
    logic          r_int;
    logic          r_ready;

    logic          w_rd_acc;
    logic          w_wr_acc;
    logic          w_rd_edge;
    logic          w_wr_edge;
    logic [7:0]    w_port;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_status_rd;
    logic          w_reply_wr;
    logic [15:0]   w_head;
    logic [7:0]    w_din_next;

    assign w_rd_acc    = io_cpu_iorq & io_cpu_rd;
    assign w_wr_acc    = io_cpu_iorq & io_cpu_wr;
    assign w_rd_edge   = w_rd_acc & ~r_rd_acc_q;
    assign w_wr_edge   = w_wr_acc & ~r_wr_acc_q;
    assign w_port      = io_cpu_addr[7:0];
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_pop       = w_rd_edge & (w_port == CMD_HI_PORT) & ~w_empty;
    // A pop on the same clock frees a slot, so a push into a full FIFO is kept.
    assign w_push      = io_main_wr & (~w_full | w_pop);
    assign w_drop      = io_main_wr & w_full & ~w_pop;
    assign w_status_rd = w_rd_edge & (w_port == STATUS_PORT);
    assign w_reply_wr  = w_wr_edge & (w_port == REPLY_PORT);

    // Read-data mux for the currently addressed port.
    always_comb begin
        w_din_next = 8'hFF;
        unique case (1'b1)
            (w_port == STATUS_PORT):
                w_din_next = {5'b0, r_ovf, r_reply_valid, ~w_empty};
            (w_port == CMD_LO_PORT):
                if (!w_empty) w_din_next = w_head[7:0];
            (w_port == CMD_HI_PORT):
                if (!w_empty) w_din_next = w_head[15:8];
            default: w_din_next = 8'hFF;
        endcase
    end

    // Command storage; contents need no reset, the count says what is valid.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= io_main_data;
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Strobe history for first-clock-of-access detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_acc_q <= 1'b0;
            r_wr_acc_q <= 1'b0;
        end else begin
            r_rd_acc_q <= w_rd_acc;
            r_wr_acc_q <= w_wr_acc;
        end
    end

    // Sticky overflow; a new drop beats a simultaneous status read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)           r_ovf <= 1'b0;
        else if (w_drop)      r_ovf <= 1'b1;
        else if (w_status_rd) r_ovf <= 1'b0;
    end

    // Reply latch; a Z80 write beats a same-clock consume from the main CPU.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_reply       <= 8'h00;
            r_reply_valid <= 1'b0;
        end else if (w_reply_wr) begin
            r_reply       <= io_cpu_dout;
            r_reply_valid <= 1'b1;
        end else if (io_main_rd) begin
            r_reply_valid <= 1'b0;
        end
    end

    // Read data is frozen after the first clock of an access so a pop or
    // status clear cannot change the byte the Z80 is about to latch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                       r_din <= 8'hFF;
        else if (!(w_rd_acc && r_rd_acc_q)) r_din <= w_din_next;
    end

    // Registered level interrupt and main-side ready from the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_int   <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_int   <= ~w_empty;
            r_ready <= ~w_full;
        end
    end

    assign io_cpu_din          = r_din;
    assign io_cpu_int          = r_int;
    assign io_main_ready       = r_ready;
    assign io_main_reply       = r_reply;
    assign io_main_reply_valid = r_reply_valid;

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Scoreboard bench for sound_latch_bridge: model FIFO of command words,
// expected read bytes queued at stimulus time and popped at Z80 reads.
module tb_sound_latch_bridge;

    localparam int         DEPTH = 4;
    localparam logic [7:0] P_STAT = 8'h00;
    localparam logic [7:0] P_LO   = 8'h10;
    localparam logic [7:0] P_HI   = 8'h20;
    localparam logic [7:0] P_REP  = 8'h30;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_main_wr = 1'b0;
    logic [15:0] io_main_data = 16'h0;
    logic        io_main_ready;
    logic        io_main_rd = 1'b0;
    logic [7:0]  io_main_reply;
    logic        io_main_reply_valid;
    logic [15:0] io_cpu_addr = 16'h0;
    logic [7:0]  io_cpu_dout = 8'h0;
    logic [7:0]  io_cpu_din;
    logic        io_cpu_rd = 1'b0;
    logic        io_cpu_wr = 1'b0;
    logic        io_cpu_iorq = 1'b0;
    logic        io_cpu_int;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_q[$];
    logic        m_ovf = 1'b0;
    logic        m_valid = 1'b0;
    logic [7:0]  sb[$];

    always #5 clock = ~clock;

    sound_latch_bridge #(
        .DEPTH(DEPTH), .STATUS_PORT(P_STAT), .CMD_LO_PORT(P_LO),
        .CMD_HI_PORT(P_HI), .REPLY_PORT(P_REP)
    ) dut (
        .clock(clock), .reset(reset),
        .io_main_wr(io_main_wr), .io_main_data(io_main_data),
        .io_main_ready(io_main_ready), .io_main_rd(io_main_rd),
        .io_main_reply(io_main_reply),
        .io_main_reply_valid(io_main_reply_valid),
        .io_cpu_addr(io_cpu_addr), .io_cpu_dout(io_cpu_dout),
        .io_cpu_din(io_cpu_din), .io_cpu_rd(io_cpu_rd),
        .io_cpu_wr(io_cpu_wr), .io_cpu_iorq(io_cpu_iorq),
        .io_cpu_int(io_cpu_int)
    );

    function automatic logic [7:0] m_status();
        return {5'b0, m_ovf, m_valid, (m_q.size() != 0)};
    endfunction

    task automatic m_push(input logic [15:0] w);
        if (m_q.size() < DEPTH) m_q.push_back(w);
        else m_ovf = 1'b1;
    endtask

    task automatic main_push(input logic [15:0] w);
        @(negedge clock);
        io_main_wr = 1'b1;
        io_main_data = w;
        @(negedge clock);
        io_main_wr = 1'b0;
        m_push(w);
    endtask

    task automatic z80_read(input logic [7:0] port, output logic [7:0] d);
        @(negedge clock);
        io_cpu_addr = {8'h00, port};
        io_cpu_iorq = 1'b1;
        io_cpu_rd = 1'b1;
        repeat (8) @(posedge clock);
        @(negedge clock);
        d = io_cpu_din;
        io_cpu_iorq = 1'b0;
        io_cpu_rd = 1'b0;
    endtask

    task automatic z80_write(input logic [7:0] port, input logic [7:0] v);
        @(negedge clock);
        io_cpu_addr = {8'h00, port};
        io_cpu_dout = v;
        io_cpu_iorq = 1'b1;
        io_cpu_wr = 1'b1;
        repeat (8) @(posedge clock);
        @(negedge clock);
        io_cpu_iorq = 1'b0;
        io_cpu_wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic [7:0] e;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({io_cpu_int, io_main_ready, io_main_reply_valid} !== 3'b010) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 010",
                     {io_cpu_int, io_main_ready, io_main_reply_valid});
        end
        n_cmp++;
        if (io_cpu_din !== 8'hFF) begin
            n_bad++;
            $display("FAIL reset_din got %h want ff", io_cpu_din);
        end
        n_cmp++;
        if (io_main_reply !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_reply got %h want 00", io_main_reply);
        end
        reset = 1'b1;
        sb.push_back(m_status());
        z80_read(P_STAT, d);
        e = sb.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL reset_status got %h want %h", d, e);
        end
        sb.push_back(8'hFF);
        z80_read(P_LO, d);
        e = sb.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL empty_lo got %h want %h", d, e);
        end
    endtask

    task automatic read_pair(input string tag);
        logic [7:0] d;
        logic [7:0] e;
        sb.push_back(m_q[0][7:0]);
        z80_read(P_LO, d);
        e = sb.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL %s_lo got %h want %h", tag, d, e);
        end
        sb.push_back(m_q[0][15:8]);
        z80_read(P_HI, d);
        void'(m_q.pop_front());
        e = sb.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL %s_hi got %h want %h", tag, d, e);
        end
    endtask

    task automatic read_status(input string tag);
        logic [7:0] d;
        logic [7:0] e;
        sb.push_back(m_status());
        m_ovf = 1'b0;
        z80_read(P_STAT, d);
        e = sb.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL %s got %h want %h", tag, d, e);
        end
    endtask

    task automatic test_single();
        main_push(16'hA55A);
        n_cmp++;
        if (io_cpu_int !== 1'b0) begin
            n_bad++;
            $display("FAIL int_early got %b want 0", io_cpu_int);
        end
        @(negedge clock);
        n_cmp++;
        if (io_cpu_int !== 1'b1) begin
            n_bad++;
            $display("FAIL int_rise got %b want 1", io_cpu_int);
        end
        main_push(16'h1234);
        read_pair("single_a55a");
        read_status("single_one_pop");
        read_pair("single_1234");
        n_cmp++;
        if (io_cpu_int !== 1'b0) begin
            n_bad++;
            $display("FAIL int_fall got %b want 0", io_cpu_int);
        end
    endtask

    task automatic test_overflow();
        main_push(16'h1101);
        main_push(16'h2202);
        main_push(16'h3303);
        main_push(16'h4404);
        @(negedge clock);
        n_cmp++;
        if (io_main_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_ready got %b want 0", io_main_ready);
        end
        main_push(16'h5505);
        read_status("ovf_status");
        read_status("ovf_cleared");
        for (int i = 0; i < 4; i++) read_pair("wrap");
        @(negedge clock);
        n_cmp++;
        if ({io_cpu_int, io_main_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL drained got %b want 01",
                     {io_cpu_int, io_main_ready});
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] d;
        logic [7:0] e;
        main_push(16'hA1A1);
        main_push(16'hA2A2);
        main_push(16'hA3A3);
        main_push(16'hA4A4);
        sb.push_back(m_q[0][15:8]);
        @(negedge clock);
        io_cpu_addr = {8'h00, P_HI};
        io_cpu_iorq = 1'b1;
        io_cpu_rd = 1'b1;
        io_main_wr = 1'b1;
        io_main_data = 16'hBEEF;
        @(negedge clock);
        io_main_wr = 1'b0;
        void'(m_q.pop_front());
        m_push(16'hBEEF);
        repeat (7) @(posedge clock);
        @(negedge clock);
        d = io_cpu_din;
        io_cpu_iorq = 1'b0;
        io_cpu_rd = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL simul_hi got %h want %h", d, e);
        end
        n_cmp++;
        if (io_main_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_full got %b want 0", io_main_ready);
        end
        read_status("simul_no_ovf");
        for (int i = 0; i < 4; i++) read_pair("simul_drain");
    endtask

    task automatic test_reply();
        z80_write(P_REP, 8'h3C);
        m_valid = 1'b1;
        n_cmp++;
        if ({io_main_reply_valid, io_main_reply} !== {1'b1, 8'h3C}) begin
            n_bad++;
            $display("FAIL reply_3c got %b/%h want 1/3c",
                     io_main_reply_valid, io_main_reply);
        end
        read_status("reply_status");
        @(negedge clock);
        io_cpu_addr = {8'h00, P_REP};
        io_cpu_dout = 8'h77;
        io_cpu_iorq = 1'b1;
        io_cpu_wr = 1'b1;
        io_main_rd = 1'b1;
        @(negedge clock);
        io_main_rd = 1'b0;
        repeat (7) @(posedge clock);
        @(negedge clock);
        io_cpu_iorq = 1'b0;
        io_cpu_wr = 1'b0;
        n_cmp++;
        if ({io_main_reply_valid, io_main_reply} !== {1'b1, 8'h77}) begin
            n_bad++;
            $display("FAIL reply_write_wins got %b/%h want 1/77",
                     io_main_reply_valid, io_main_reply);
        end
        @(negedge clock);
        io_main_rd = 1'b1;
        @(negedge clock);
        io_main_rd = 1'b0;
        m_valid = 1'b0;
        n_cmp++;
        if ({io_main_reply_valid, io_main_reply} !== {1'b0, 8'h77}) begin
            n_bad++;
            $display("FAIL reply_consume got %b/%h want 0/77",
                     io_main_reply_valid, io_main_reply);
        end
    endtask

    task automatic test_reset_mid();
        main_push(16'hC0DE);
        main_push(16'h1357);
        @(negedge clock);
        io_cpu_addr = {8'h00, P_HI};
        io_cpu_iorq = 1'b1;
        io_cpu_rd = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        m_valid = 1'b0;
        #1;
        n_cmp++;
        if ({io_cpu_int, io_main_ready, io_main_reply_valid} !== 3'b010) begin
            n_bad++;
            $display("FAIL midrst_flags got %b want 010",
                     {io_cpu_int, io_main_ready, io_main_reply_valid});
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        main_push(16'h2468);
        repeat (3) @(negedge clock);
        n_cmp++;
        if (io_cpu_din !== 8'hFF) begin
            n_bad++;
            $display("FAIL midrst_din got %h want ff", io_cpu_din);
        end
        n_cmp++;
        if (io_cpu_int !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_no_pop got %b want 1", io_cpu_int);
        end
        io_cpu_iorq = 1'b0;
        io_cpu_rd = 1'b0;
        read_status("midrst_status");
        read_pair("midrst_fresh");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_reply();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
